fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter DATA_W, default 32, instruction width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 32, PC width in bits.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of 2, at least 2.
REQ-004 Ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  start_pc  in  ADDR_W  boot PC, sampled while rst=1.
  imem_req  out  1  fetch request this cycle.
  imem_addr  out  ADDR_W  fetch address, registered.
  imem_rdata  in  DATA_W  instruction, valid exactly 1 cycle after the accepted request.
  redirect  in  1  branch/jump taken; flush and refetch.
  redirect_pc  in  ADDR_W  target PC when redirect=1.
  deq  in  1  decode stage accepts the head entry (IF/ID write enable).
  out_valid  out  1  head entry present.
  out_instr  out  DATA_W  head instruction.
  out_pcplus4  out  ADDR_W  head PC + DATA_W/8.
  count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-005 The queue SHALL be a circular FIFO of DEPTH entries, each holding {instr, pc}, with rd_ptr/wr_ptr wrapping modulo DEPTH.
REQ-006 The block SHALL issue imem_req=1 only when count + inflight < DEPTH, where inflight is 1 when a request was issued on the previous cycle and its response is not being squashed.
REQ-007 On each accepted request, fetch_pc SHALL advance by DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-008 On the cycle after a request, imem_rdata SHALL be written at wr_ptr with its issuing PC, unless squashed.
REQ-009 out_valid SHALL equal (count != 0) AND NOT redirect; out_instr and out_pcplus4 SHALL be driven combinationally from the head entry.
REQ-010 deq with out_valid=1 SHALL pop the head at the clock edge; deq with out_valid=0 SHALL be ignored.
REQ-011 Simultaneous push and pop SHALL leave count unchanged; the queue can never overflow (REQ-006), and a pop on an empty queue SHALL never occur.
REQ-012 The FSM SHALL have two states: RUN (normal operation) and SQUASH (one cycle, after a redirect).
REQ-013 Transition RUN->SQUASH SHALL occur when redirect=1; SQUASH->RUN SHALL be unconditional unless redirect=1 again, which SHALL keep the FSM in SQUASH.
REQ-014 On redirect=1 at edge E0: queue emptied (count=0, pointers equal); fetch_pc <= redirect_pc; deq in that cycle ignored.
REQ-015 In SQUASH, the response to any pre-redirect request SHALL be discarded, and imem_req=1 with imem_addr=redirect_pc.
REQ-016 Redirect-to-first-valid latency SHALL be exactly 2 cycles: out_valid=1 with that PC after edge E2.
REQ-017 Steady-state throughput with deq held at 1 SHALL be one instruction per cycle.

Reset
REQ-018 While rst=1: count=0, pointers=0, inflight=0, state=RUN, fetch_pc/imem_addr=start_pc, imem_req=0, out_valid=0, and all queue storage =0 (out_instr=0, out_pcplus4=0).
REQ-019 In the first cycle with rst=0, imem_req SHALL be 1 with imem_addr=start_pc.
REQ-020 rst asserted mid-operation SHALL override redirect and deq, and discard any in-flight response.

Structure
REQ-021 The shared processor package SHALL hold default DATA_W/ADDR_W/DEPTH and the FSM state encoding.
REQ-022 Storage SHALL be one sub-module, fetch_fifo_mem (DEPTH x (DATA_W+ADDR_W) register array, one write port, one async read port); all control SHALL stay in fetch_queue_unit.

Verification
REQ-023 Boot fill: start_pc=300, deq=0 -> requests to 300, 304, 308, 312; count reaches 4, then imem_req=0; out_instr=mem[300], out_pcplus4=304.
REQ-024 Streaming: deq=1 continuously from start_pc=300 -> one entry per cycle, out_pcplus4=304, 308, 312, ...; count never exceeds 2.
REQ-025 Redirect: with count=3 and a request in flight, redirect_pc=116 -> next cycle count=0, imem_addr=116; the old response is dropped; out_valid=1 with out_pcplus4=120 two cycles after redirect.
REQ-026 Redirect with deq in the same cycle -> head not counted as consumed; out_valid=0 that cycle; no stale PC ever appears afterwards.
REQ-027 Back-to-back redirects to 200 then 400 -> only PCs from 400 onward are enqueued.
REQ-028 rst mid-stream with start_pc=64 -> all REQ-018 values after one edge; first request to 64; DEPTH=2 build: count never exceeds 2.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_pkg
// Shared processor package for the instruction fetch front end.
// Holds the default instruction/PC widths, the prefetch queue depth and the
// state encoding of the fetch control FSM.
// ---------------------------------------------------------------------------
package fetch_queue_unit_pkg;

    localparam int FQ_DATA_W = 32;
    localparam int FQ_ADDR_W = 32;
    localparam int FQ_DEPTH  = 4;

    // RUN is normal fetching; SQUASH is the single cycle after a redirect in
    // which the response to the pre-redirect request is thrown away.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } fq_state_e;

endpackage

// File: rtl/fetch_fifo_mem.sv
// ---------------------------------------------------------------------------
// fetch_fifo_mem
// Storage array for the prefetch queue: DEPTH entries of {instr, pc}, one
// synchronous write port and one asynchronous read port. Holds no control;
// pointers and occupancy live in fetch_queue_unit.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset, clears every entry
//   we     in  write enable
//   waddr  in  write index
//   wdata  in  entry to write {instr, pc}
//   raddr  in  read index
//   rdata  out entry at raddr (combinational)
// ---------------------------------------------------------------------------
module fetch_fifo_mem
    import fetch_queue_unit_pkg::*;
#(
    parameter int DATA_W = FQ_DATA_W,
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int DEPTH  = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W+ADDR_W-1:0]   wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W+ADDR_W-1:0]   rdata
);

    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Reset clears the storage so an empty queue never shows stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Instruction prefetch queue. Issues fetch requests to instruction memory
// (response one cycle later), buffers up to DEPTH {instr, pc} entries and
// hands the head entry to decode. A redirect flushes the queue and refetches
// from the target; the stale response in flight is dropped.
// Ports:
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   start_pc     in  boot PC, sampled while rst=1
//   imem_req     out fetch request this cycle
//   imem_addr    out fetch address (registered fetch PC)
//   imem_rdata   in  instruction, valid one cycle after an accepted request
//   redirect     in  taken branch/jump: flush and refetch
//   redirect_pc  in  target PC when redirect=1
//   deq          in  decode accepts the head entry
//   out_valid    out head entry present
//   out_instr    out head instruction
//   out_pcplus4  out head PC + DATA_W/8
//   count        out occupied entries
// ---------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int DATA_W = FQ_DATA_W,
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int DEPTH  = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          start_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       deq,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pcplus4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(DATA_W / 8);

    fq_state_e          state, next_state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               req_q;
    logic [ADDR_W-1:0]  req_pc_q;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               squash;
    logic               inflight;
    logic [CNT_W:0]     occupancy;
    logic               head_live;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [DATA_W-1:0]  head_instr;
    logic [ADDR_W-1:0]  head_pc;

    // Control decode. A request is only issued if the queue can still hold
    // its response, counting the one already in flight, so the queue can
    // never overflow. The response arriving during SQUASH belongs to a
    // pre-redirect request and does not count as in flight.
    always_comb begin
        squash    = (state == ST_SQUASH);
        inflight  = req_q && !squash;
        occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight);
        imem_req  = !rst && (occupancy < (CNT_W+1)'(DEPTH));
        head_live = !rst && (count_q != '0);
        out_valid = head_live && !redirect;
        push      = req_q && !squash && !redirect && !rst;
        pop       = deq && out_valid;
    end

    // FSM next state: any redirect lands in (or stays in) SQUASH for one cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:    if (redirect) next_state = ST_SQUASH;
            ST_SQUASH: next_state = redirect ? ST_SQUASH : ST_RUN;
            default:   next_state = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Fetch PC, request tracking, queue pointers and occupancy. A redirect
    // empties the queue by snapping rd_ptr onto wr_ptr, overriding any
    // push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= start_pc;
            req_q    <= 1'b0;
            req_pc_q <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            req_q <= imem_req;
            if (imem_req) begin
                req_pc_q <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= wr_ptr;
                count_q  <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    fetch_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({imem_rdata, req_pc_q}),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    assign head_instr = head_entry[ENTRY_W-1:ADDR_W];
    assign head_pc    = head_entry[ADDR_W-1:0];

    // Head outputs read as zero whenever there is no live entry.
    assign out_instr   = head_live ? head_instr : '0;
    assign out_pcplus4 = head_live ? (head_pc + INSTR_BYTES) : '0;
    assign imem_addr   = fetch_pc;
    assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
// Drives a DEPTH=4 and a DEPTH=2 fetch_queue_unit with the same control
// inputs; each has its own instruction memory responder. Expected outputs
// come from a behavioural model: an ordered list of {instr, pc} entries, a
// fetch PC and a record of the last request tagged as killed when a
// redirect overtook it.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        deq;
    logic        redirect;
    logic [31:0] start_pc;
    logic [31:0] redirect_pc;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1;
    logic [31:0] instr0, instr1;
    logic [31:0] p4_0, p4_1;
    logic [2:0]  count0;
    logic [1:0]  count1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural model state, one slot per instance.
    logic [31:0] mq_instr [2][4];
    logic [31:0] mq_pc    [2][4];
    int          msize    [2];
    logic [31:0] mfetch   [2];
    bit          pend_v   [2];
    bit          pend_kill[2];
    logic [31:0] pend_pc  [2];
    bit          e_req    [2];

    always #5 clk = ~clk;

    fetch_queue_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u_dut (
        .clk (clk), .rst (rst), .start_pc (start_pc),
        .imem_req (req0), .imem_addr (addr0), .imem_rdata (rdata0),
        .redirect (redirect), .redirect_pc (redirect_pc), .deq (deq),
        .out_valid (valid0), .out_instr (instr0), .out_pcplus4 (p4_0),
        .count (count0)
    );

    fetch_queue_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) u_dut2 (
        .clk (clk), .rst (rst), .start_pc (start_pc),
        .imem_req (req1), .imem_addr (addr1), .imem_rdata (rdata1),
        .redirect (redirect), .redirect_pc (redirect_pc), .deq (deq),
        .out_valid (valid1), .out_instr (instr1), .out_pcplus4 (p4_1),
        .count (count1)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Instruction memory: data for the address presented at an edge is
    // available during the following cycle.
    always @(posedge clk) begin
        rdata0 <= mem_fn(addr0);
        rdata1 <= mem_fn(addr1);
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s c%0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic d, input logic rd,
                                 input logic [31:0] rpc, input logic [31:0] spc);
        rst         = r;
        deq         = d;
        redirect    = rd;
        redirect_pc = rpc;
        start_pc    = spc;
        @(negedge clk);
    endtask

    task automatic modelStep(input int i);
        bit arrive;
        arrive = pend_v[i] && !pend_kill[i];
        if (rst) begin
            msize[i]  = 0;
            mfetch[i] = start_pc;
            pend_v[i] = 1'b0;
        end else if (redirect) begin
            msize[i]     = 0;
            pend_v[i]    = e_req[i];
            pend_kill[i] = 1'b1;
            pend_pc[i]   = mfetch[i];
            mfetch[i]    = redirect_pc;
        end else begin
            if (deq && msize[i] > 0) begin
                for (int k = 0; k < 3; k++) begin
                    mq_instr[i][k] = mq_instr[i][k+1];
                    mq_pc[i][k]    = mq_pc[i][k+1];
                end
                msize[i]--;
            end
            if (arrive && msize[i] < depth_of(i)) begin
                mq_instr[i][msize[i]] = mem_fn(pend_pc[i]);
                mq_pc[i][msize[i]]    = pend_pc[i];
                msize[i]++;
            end
            pend_v[i]    = e_req[i];
            pend_kill[i] = 1'b0;
            pend_pc[i]   = mfetch[i];
            if (e_req[i]) mfetch[i] = mfetch[i] + 32'd4;
        end
    endtask

    // Compare both instances against the model at the negedge, then advance
    // the model and the clock to just after the next rising edge.
    task automatic checkOutput();
        logic        o_req, o_valid;
        logic [31:0] o_addr, o_instr, o_p4, o_cnt;
        bit          live, infl;
        logic [31:0] e_instr, e_p4;
        for (int i = 0; i < 2; i++) begin
            o_req   = (i == 0) ? req0   : req1;
            o_valid = (i == 0) ? valid0 : valid1;
            o_addr  = (i == 0) ? addr0  : addr1;
            o_instr = (i == 0) ? instr0 : instr1;
            o_p4    = (i == 0) ? p4_0   : p4_1;
            o_cnt   = (i == 0) ? {29'b0, count0} : {30'b0, count1};
            infl     = pend_v[i] && !pend_kill[i];
            e_req[i] = !rst && ((msize[i] + int'(infl)) < depth_of(i));
            live     = !rst && (msize[i] > 0);
            e_instr  = live ? mq_instr[i][0] : 32'h0;
            e_p4     = live ? mq_pc[i][0] + 32'd4 : 32'h0;
            cmp($sformatf("imem_req[%0d]", i),   {31'b0, o_req},   {31'b0, e_req[i]});
            cmp($sformatf("imem_addr[%0d]", i),  o_addr,           mfetch[i]);
            cmp($sformatf("count[%0d]", i),      o_cnt,            32'(msize[i]));
            cmp($sformatf("out_valid[%0d]", i),  {31'b0, o_valid}, {31'b0, live && !redirect});
            cmp($sformatf("out_instr[%0d]", i),  o_instr,          e_instr);
            cmp($sformatf("out_pcplus4[%0d]", i), o_p4,            e_p4);
        end
        cmp("depth2_bound", {31'b0, (count1 <= 2'd2)}, 32'd1);
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int max_cnt;
        logic [31:0] spc;

        for (int i = 0; i < 2; i++) begin
            msize[i]     = 0;
            mfetch[i]    = 32'd300;
            pend_v[i]    = 1'b0;
            pend_kill[i] = 1'b0;
            pend_pc[i]   = 32'h0;
            e_req[i]     = 1'b0;
        end
        rst = 1'b1; deq = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; start_pc = 32'd300;
        @(posedge clk);
        #1;

        $display("[TB] reset and boot fill from 300");
        for (int n = 0; n < 3; n++) begin applyStimulus(1, 0, 0, 0, 300); checkOutput(); end
        for (int n = 0; n < 8; n++) begin applyStimulus(0, 0, 0, 0, 300); checkOutput(); end

        $display("[TB] streaming with deq held high");
        for (int n = 0; n < 2; n++) begin applyStimulus(1, 1, 0, 0, 300); checkOutput(); end
        max_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            applyStimulus(0, 1, 0, 0, 300);
            if (int'(count0) > max_cnt) max_cnt = int'(count0);
            checkOutput();
        end
        cmp("stream_max_count_le2", {31'b0, (max_cnt <= 2)}, 32'd1);

        $display("[TB] redirect to 116 with count=3 and a request in flight");
        for (int n = 0; n < 2; n++) begin applyStimulus(1, 0, 0, 0, 300); checkOutput(); end
        for (int n = 0; n < 4; n++) begin applyStimulus(0, 0, 0, 0, 300); checkOutput(); end
        applyStimulus(0, 0, 1, 116, 300); checkOutput();
        for (int n = 0; n < 5; n++) begin applyStimulus(0, 0, 0, 0, 300); checkOutput(); end

        $display("[TB] redirect with deq in the same cycle");
        applyStimulus(0, 1, 1, 500, 300); checkOutput();
        for (int n = 0; n < 6; n++) begin applyStimulus(0, n[0], 0, 0, 300); checkOutput(); end

        $display("[TB] back-to-back redirects to 200 then 400");
        applyStimulus(0, 0, 1, 200, 300); checkOutput();
        applyStimulus(0, 0, 1, 400, 300); checkOutput();
        for (int n = 0; n < 6; n++) begin applyStimulus(0, 0, 0, 0, 300); checkOutput(); end
        for (int n = 0; n < 6; n++) begin applyStimulus(0, 1, 0, 0, 300); checkOutput(); end

        $display("[TB] reset mid-stream with start_pc=64");
        applyStimulus(1, 1, 1, 900, 64); checkOutput();
        for (int n = 0; n < 8; n++) begin applyStimulus(0, 1, 0, 0, 64); checkOutput(); end

        $display("[TB] randomized traffic");
        spc = 32'd64;
        for (int n = 0; n < 400; n++) begin
            logic r, d, rd;
            r  = ($urandom_range(0, 63) == 0);
            d  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 11) == 0);
            if (r) spc = $urandom & 32'hFFFF_FFFC;
            applyStimulus(r, d, rd, $urandom & 32'hFFFF_FFFC, spc);
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
